wb_commit: RTL and testbench
============================

Name: wb_commit

Overview:
- Writeback commit stage: the writer side of the 8x19 register-file write port.
- Merges two result streams into the single write port (`wb_rd_addr`, `wb_data`, `wb_reg_write`):
  - the in-order pipeline result;
  - the out-of-order FFT/crypto accelerator result.
- Buffers accelerator results in a small FIFO and keeps a busy scoreboard, so decode can stall on pending accelerator destinations.

Parameters:
- DATA_W, 19, register/result data width
- ADDR_W, 3, register address width (2**ADDR_W registers)
- FIFO_DEPTH, 2, accelerator result FIFO entries (power of two, >=2)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- pipe_valid  input  1  pipeline result valid this cycle; never stalled
- pipe_rd  input  ADDR_W  pipeline destination register
- pipe_data  input  DATA_W  pipeline result
- acc_valid  input  1  accelerator result offered
- acc_ready  output  1  FIFO can accept; transfer when acc_valid && acc_ready
- acc_rd  input  ADDR_W  accelerator destination register
- acc_data  input  DATA_W  accelerator result
- issue_valid  input  1  accelerator op issued this cycle
- issue_rd  input  ADDR_W  destination of issued accelerator op
- wb_reg_write  output  1  register-file write enable
- wb_rd_addr  output  ADDR_W  register-file write address
- wb_data  output  DATA_W  register-file write data
- busy_mask  output  2**ADDR_W  bit i=1: accelerator write to ri pending
- fifo_count  output  ADDR_W  current FIFO occupancy (0..FIFO_DEPTH)

Behaviour:
- Reset values (async, immediate on rst_n=0):
  - wb_reg_write=0, wb_rd_addr=0, wb_data=0;
  - busy_mask=0, fifo_count=0, FIFO pointers=0;
  - acc_ready=1 after reset release.
  - Reset mid-operation discards all FIFO contents and pending busy bits.
- Write-port outputs are registered. A pipeline result appears on wb_* the cycle after pipe_valid; wb_reg_write is a 1-cycle pulse per committed result.
- Arbitration, each cycle:
  - pipe_valid=1: commit pipeline result; FIFO does not pop.
  - pipe_valid=0 and fifo_count>0: pop FIFO head and commit it.
  - Otherwise wb_reg_write=0 next cycle; wb_rd_addr/wb_data hold their last values.
- Destination r0: any result with rd=0 is consumed (FIFO still pops) but wb_reg_write stays 0.
- FIFO:
  - acc_ready = (fifo_count < FIFO_DEPTH), combinational from registered count.
  - Push on acc_valid && acc_ready. Pop per the arbitration rule.
  - Push and pop in the same cycle: count unchanged.
  - A full FIFO accepts no push, even when popping that cycle (no same-cycle refill).
  - Pointers wrap modulo FIFO_DEPTH. Entries commit in push order.
- Scoreboard:
  - issue_valid with issue_rd!=0 sets busy_mask[issue_rd] on the next edge.
  - Committing an accelerator result (popped from FIFO, or bypassed) clears busy_mask[rd].
  - Set and clear of the same bit in one cycle: set wins (a newer op is pending).
  - Pipeline commits never change busy_mask. busy_mask[0] is always 0.
- Starvation: accelerator results wait as long as pipe_valid stays high. acc_ready deasserts when full; the accelerator must hold acc_valid/acc_rd/acc_data until accepted.
- Widths: data is passed through unmodified; no arithmetic on data.

Optional Feature:
- Macro: WB_ACC_BYPASS_EN
- Defined:
  - When pipe_valid=0 and fifo_count=0, an accepted accelerator result skips the FIFO.
  - It is committed on the next edge (latency 1), fifo_count stays 0, and its busy bit clears on that edge.
- Undefined:
  - Every accelerator result is pushed into the FIFO first.
  - Minimum accept-to-wb_reg_write latency is 2 cycles.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 FIFO entries and busy_mask=8'h14 -> all outputs 0 immediately; acc_ready=1 after release; no stale writes.
- Pipeline only: pipe_valid=1, rd=5, data=19'h12345 -> next cycle wb_reg_write=1, wb_rd_addr=5, wb_data=19'h12345; pulse lasts 1 cycle.
- Priority and ordering:
  - Push acc results (rd=3, data=19'h00AAA) then (rd=4, data=19'h00BBB) while pipe_valid=1 for 4 cycles -> fifo_count=2, acc_ready=0, no acc commits.
  - Then drop pipe_valid -> rd=3 committed, then rd=4, on consecutive cycles.
- Scoreboard: issue rd=6 -> busy_mask=8'h40; acc commit rd=6 -> busy_mask=8'h00. Simultaneous issue rd=6 and commit rd=6 -> busy_mask stays 8'h40.
- r0: pipe rd=0 and acc rd=0 results -> wb_reg_write never asserts; FIFO still drains to count 0.
- Bypass:
  - With WB_ACC_BYPASS_EN, idle, acc rd=2 data=19'h7FFFF -> commit 1 cycle after accept.
  - Without the macro -> commit 2 cycles after accept, fifo_count=1 in between.

Source files
------------

// File: rtl/wb_commit.sv
// Writeback commit stage: merges the in-order pipeline result stream and the
// out-of-order accelerator result stream onto the single register-file write
// port. Accelerator results wait in a small FIFO and are tracked in a busy
// scoreboard so decode can stall on pending accelerator destinations.
// Optional feature macro WB_ACC_BYPASS_EN: an accelerator result arriving while
// the pipeline is idle and the FIFO is empty commits directly, skipping the FIFO.
module wb_commit #(
  parameter int DATA_W     = 19,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_valid,
  input  logic [ADDR_W-1:0]     pipe_rd,
  input  logic [DATA_W-1:0]     pipe_data,
  input  logic                  acc_valid,
  output logic                  acc_ready,
  input  logic [ADDR_W-1:0]     acc_rd,
  input  logic [DATA_W-1:0]     acc_data,
  input  logic                  issue_valid,
  input  logic [ADDR_W-1:0]     issue_rd,
  output logic                  wb_reg_write,
  output logic [ADDR_W-1:0]     wb_rd_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic [2**ADDR_W-1:0]  busy_mask,
  output logic [ADDR_W-1:0]     fifo_count
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NREG  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_rd   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  logic              accept, bypass, push, pop;
  logic              commit_en, acc_commit;
  logic [ADDR_W-1:0] commit_rd;
  logic [DATA_W-1:0] commit_data;
  logic [NREG-1:0]   busy_next;
  logic [ADDR_W-1:0] count_next;

  // A full FIFO refuses new results even when it pops this cycle.
  assign acc_ready = (fifo_count < DEPTH_C);

  // Arbitration: pipeline first, then FIFO head, then (optionally) bypass.
  always_comb begin
    accept = acc_valid && acc_ready;
    pop    = !pipe_valid && (fifo_count != '0);
`ifdef WB_ACC_BYPASS_EN
    bypass = accept && !pipe_valid && (fifo_count == '0);
`else
    bypass = 1'b0;
`endif
    push       = accept && !bypass;
    commit_en  = pipe_valid || pop || bypass;
    acc_commit = pop || bypass;

    commit_rd   = acc_rd;
    commit_data = acc_data;
    if (pipe_valid) begin
      commit_rd   = pipe_rd;
      commit_data = pipe_data;
    end else if (pop) begin
      commit_rd   = mem_rd[rd_ptr];
      commit_data = mem_data[rd_ptr];
    end

    // Clear first, then set, so a newly issued op on the same register wins.
    busy_next = busy_mask;
    if (acc_commit) busy_next[commit_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;

    count_next = fifo_count;
    if (push && !pop)      count_next = fifo_count + ADDR_W'(1);
    else if (pop && !push) count_next = fifo_count - ADDR_W'(1);
  end

  // FIFO storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= acc_data;
      mem_rd[wr_ptr]   <= acc_rd;
    end
  end

  // Pointers, occupancy, scoreboard and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      busy_mask    <= '0;
      wb_reg_write <= 1'b0;
      wb_rd_addr   <= '0;
      wb_data      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count   <= count_next;
      busy_mask    <= busy_next;
      // r0 results are consumed but never written.
      wb_reg_write <= commit_en && (commit_rd != '0);
      if (commit_en) begin
        wb_rd_addr <= commit_rd;
        wb_data    <= commit_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: table-driven pipeline vectors, hand-written
// sequences for FIFO ordering, scoreboard, r0, bypass and reset, and a write
// scoreboard queue that checks every wb_reg_write pulse in commit order.
module tb_wb_commit;

  logic        clk;
  logic        rst_n;
  logic        pipe_valid;
  logic [2:0]  pipe_rd;
  logic [18:0] pipe_data;
  logic        acc_valid;
  logic        acc_ready;
  logic [2:0]  acc_rd;
  logic [18:0] acc_data;
  logic        issue_valid;
  logic [2:0]  issue_rd;
  logic        wb_reg_write;
  logic [2:0]  wb_rd_addr;
  logic [18:0] wb_data;
  logic [7:0]  busy_mask;
  logic [2:0]  fifo_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  a;
    logic [18:0] d;
  } wr_t;
  wr_t sbq[$];
  wr_t mon_e;

  typedef struct {
    logic        pv;
    logic [2:0]  rd;
    logic [18:0] data;
    logic        exp_we;
    logic        chk_ad;
    logic [2:0]  exp_addr;
    logic [18:0] exp_data;
  } vec_t;
  vec_t vecs[8];

  wb_commit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_valid   (pipe_valid),
    .pipe_rd      (pipe_rd),
    .pipe_data    (pipe_data),
    .acc_valid    (acc_valid),
    .acc_ready    (acc_ready),
    .acc_rd       (acc_rd),
    .acc_data     (acc_data),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .wb_reg_write (wb_reg_write),
    .wb_rd_addr   (wb_rd_addr),
    .wb_data      (wb_data),
    .busy_mask    (busy_mask),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [2:0] a, input logic [18:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sbq.push_back(e);
  endtask

  task automatic wait_we(input int max_cyc);
    for (int k = 0; k < max_cyc && !wb_reg_write; k++) step();
    tests++;
    if (!wb_reg_write) begin
      fails++;
      $display("FAIL wait_we: no write within %0d cycles", max_cyc);
    end
  endtask

  // Every write pulse must match the oldest expected commit.
  always @(posedge clk) begin
    #2;
    if (wb_reg_write) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: write addr %0h data %0h, none expected", wb_rd_addr, wb_data);
      end else begin
        mon_e = sbq.pop_front();
        if (wb_rd_addr !== mon_e.a || wb_data !== mon_e.d) begin
          fails++;
          $display("FAIL sb_order: got addr %0h data %0h expected addr %0h data %0h",
                   wb_rd_addr, wb_data, mon_e.a, mon_e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 3'd5, 19'h12345, 1'b1, 1'b1, 3'd5, 19'h12345};
    vecs[1] = '{1'b0, 3'd0, 19'h00000, 1'b0, 1'b1, 3'd5, 19'h12345};
    vecs[2] = '{1'b1, 3'd7, 19'h7FFFF, 1'b1, 1'b1, 3'd7, 19'h7FFFF};
    vecs[3] = '{1'b1, 3'd1, 19'h00001, 1'b1, 1'b1, 3'd1, 19'h00001};
    vecs[4] = '{1'b1, 3'd0, 19'h55555, 1'b0, 1'b0, 3'd0, 19'h00000};
    vecs[5] = '{1'b0, 3'd0, 19'h00000, 1'b0, 1'b0, 3'd0, 19'h00000};
    vecs[6] = '{1'b1, 3'd3, 19'h00000, 1'b1, 1'b1, 3'd3, 19'h00000};
    vecs[7] = '{1'b0, 3'd6, 19'h11111, 1'b0, 1'b1, 3'd3, 19'h00000};

    rst_n = 1'b0;
    pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    acc_valid = 1'b0; acc_rd = '0; acc_data = '0;
    issue_valid = 1'b0; issue_rd = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(wb_reg_write), 32'd0);
    chk("rst_addr", 32'(wb_rd_addr), 32'd0);
    chk("rst_data", 32'(wb_data), 32'd0);
    chk("rst_busy", 32'(busy_mask), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", 32'(acc_ready), 32'd1);

    // Pipeline-only table
    for (int i = 0; i < 8; i++) begin
      pipe_valid = vecs[i].pv;
      pipe_rd    = vecs[i].rd;
      pipe_data  = vecs[i].data;
      if (vecs[i].exp_we) sb_push(vecs[i].rd, vecs[i].data);
      step();
      chk($sformatf("vec%0d_we", i), 32'(wb_reg_write), 32'(vecs[i].exp_we));
      if (vecs[i].chk_ad) begin
        chk($sformatf("vec%0d_addr", i), 32'(wb_rd_addr), 32'(vecs[i].exp_addr));
        chk($sformatf("vec%0d_data", i), 32'(wb_data), 32'(vecs[i].exp_data));
      end
    end
    pipe_valid = 1'b0;

    // Priority and ordering: acc results wait behind a busy pipeline
    pipe_valid = 1'b1;
    pipe_rd = 3'd1;
    for (int i = 0; i < 4; i++) begin
      pipe_data = 19'(i + 16);
      sb_push(3'd1, 19'(i + 16));
      acc_valid = (i < 2);
      acc_rd    = (i == 0) ? 3'd3 : 3'd4;
      acc_data  = (i == 0) ? 19'h00AAA : 19'h00BBB;
      step();
      chk("prio_addr", 32'(wb_rd_addr), 32'd1);
    end
    acc_valid = 1'b0;
    chk("prio_count_full", 32'(fifo_count), 32'd2);
    chk("prio_ready_full", 32'(acc_ready), 32'd0);
    pipe_valid = 1'b0;
    acc_valid = 1'b1; acc_rd = 3'd5; acc_data = 19'h00CCC;
    sb_push(3'd3, 19'h00AAA);
    sb_push(3'd4, 19'h00BBB);
    sb_push(3'd5, 19'h00CCC);
    step();
    chk("drain_a_addr", 32'(wb_rd_addr), 32'd3);
    chk("drain_a_count", 32'(fifo_count), 32'd1);
    step();
    acc_valid = 1'b0;
    chk("drain_b_addr", 32'(wb_rd_addr), 32'd4);
    chk("drain_b_count", 32'(fifo_count), 32'd1);
    step();
    chk("drain_c_addr", 32'(wb_rd_addr), 32'd5);
    chk("drain_c_data", 32'(wb_data), 32'h00CCC);
    chk("drain_c_count", 32'(fifo_count), 32'd0);
    step();
    chk("drain_d_we", 32'(wb_reg_write), 32'd0);

    // Scoreboard set / clear
    issue_valid = 1'b1; issue_rd = 3'd6;
    step();
    issue_valid = 1'b0;
    chk("busy_set", 32'(busy_mask), 32'h40);
    pipe_valid = 1'b1; pipe_rd = 3'd6; pipe_data = 19'h00606;
    sb_push(3'd6, 19'h00606);
    acc_valid = 1'b1; acc_rd = 3'd6; acc_data = 19'h00666;
    step();
    acc_valid = 1'b0; pipe_valid = 1'b0;
    chk("busy_pipe_keeps", 32'(busy_mask), 32'h40);
    chk("busy_fifo_count", 32'(fifo_count), 32'd1);
    sb_push(3'd6, 19'h00666);
    step();
    chk("busy_clr_we", 32'(wb_reg_write), 32'd1);
    chk("busy_clr", 32'(busy_mask), 32'h00);

    // Same-cycle set and clear: set wins
    issue_valid = 1'b1; issue_rd = 3'd6;
    step();
    issue_valid = 1'b0;
    pipe_valid = 1'b1; pipe_rd = 3'd1; pipe_data = 19'h00011;
    sb_push(3'd1, 19'h00011);
    acc_valid = 1'b1; acc_rd = 3'd6; acc_data = 19'h00777;
    step();
    acc_valid = 1'b0; pipe_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 3'd6;
    sb_push(3'd6, 19'h00777);
    step();
    issue_valid = 1'b0;
    chk("setwin_addr", 32'(wb_rd_addr), 32'd6);
    chk("setwin_busy", 32'(busy_mask), 32'h40);
    issue_valid = 1'b1; issue_rd = 3'd0;
    step();
    issue_valid = 1'b0;
    chk("busy_r0_never", 32'(busy_mask), 32'h40);
    acc_valid = 1'b1; acc_rd = 3'd6; acc_data = 19'h00123;
    sb_push(3'd6, 19'h00123);
    step();
    acc_valid = 1'b0;
    wait_we(4);
    chk("busy_final_clr", 32'(busy_mask), 32'h00);
    step();

    // r0: consumed, never written, FIFO still drains
    pipe_valid = 1'b1; pipe_rd = 3'd0; pipe_data = 19'h00001;
    acc_valid = 1'b1; acc_rd = 3'd0; acc_data = 19'h00002;
    step();
    chk("r0_we_a", 32'(wb_reg_write), 32'd0);
    acc_data = 19'h00003;
    step();
    acc_valid = 1'b0;
    chk("r0_we_b", 32'(wb_reg_write), 32'd0);
    chk("r0_count2", 32'(fifo_count), 32'd2);
    pipe_valid = 1'b0;
    step();
    chk("r0_we_c", 32'(wb_reg_write), 32'd0);
    step();
    chk("r0_we_d", 32'(wb_reg_write), 32'd0);
    chk("r0_count0", 32'(fifo_count), 32'd0);

    // Accept-to-commit latency from idle
    acc_valid = 1'b1; acc_rd = 3'd2; acc_data = 19'h7FFFF;
    sb_push(3'd2, 19'h7FFFF);
    step();
    acc_valid = 1'b0;
`ifdef WB_ACC_BYPASS_EN
    chk("byp_we", 32'(wb_reg_write), 32'd1);
    chk("byp_addr", 32'(wb_rd_addr), 32'd2);
    chk("byp_data", 32'(wb_data), 32'h7FFFF);
    chk("byp_count", 32'(fifo_count), 32'd0);
`else
    chk("nobyp_we1", 32'(wb_reg_write), 32'd0);
    chk("nobyp_count1", 32'(fifo_count), 32'd1);
    step();
    chk("nobyp_we2", 32'(wb_reg_write), 32'd1);
    chk("nobyp_addr", 32'(wb_rd_addr), 32'd2);
    chk("nobyp_data", 32'(wb_data), 32'h7FFFF);
    chk("nobyp_count2", 32'(fifo_count), 32'd0);
`endif
    step();
    chk("lat_pulse_end", 32'(wb_reg_write), 32'd0);

    // Reset mid-operation with two FIFO entries and busy bits 2 and 4
    pipe_valid = 1'b1; pipe_rd = 3'd0; pipe_data = 19'h3AAAA;
    acc_valid = 1'b1; acc_rd = 3'd2; acc_data = 19'h02222;
    issue_valid = 1'b1; issue_rd = 3'd2;
    step();
    acc_rd = 3'd4; acc_data = 19'h04444; issue_rd = 3'd4;
    step();
    acc_valid = 1'b0; issue_valid = 1'b0;
    chk("prerst_count", 32'(fifo_count), 32'd2);
    chk("prerst_busy", 32'(busy_mask), 32'h14);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(wb_reg_write), 32'd0);
    chk("midrst_addr", 32'(wb_rd_addr), 32'd0);
    chk("midrst_data", 32'(wb_data), 32'd0);
    chk("midrst_busy", 32'(busy_mask), 32'd0);
    chk("midrst_count", 32'(fifo_count), 32'd0);
    pipe_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("postrst_ready", 32'(acc_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("postrst_no_write", 32'(wb_reg_write), 32'd0);
    end
    chk("postrst_count", 32'(fifo_count), 32'd0);

    step();
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
